// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=7 rate-1/2 hard-decision Viterbi decoder:
// trellis constants, generator taps, encoder output model and the
// wrap-safe metric comparison used by both ACS and best-state search.
package viterbi_pkg;

  localparam int K            = 7;
  localparam int NUM_STATES   = 1 << (K - 1);
  localparam int MAX_METRIC_W = 16;

  // Taps over the predecessor state p[5:0]; the input bit d is always tapped.
  localparam logic [5:0] GEN_A = 6'b110110;
  localparam logic [5:0] GEN_B = 6'b100111;

  typedef logic [MAX_METRIC_W-1:0] wide_metric_t;

  // Coded pair {A, B} emitted when input d is shifted in from state p.
  function automatic logic [1:0] exp_out(input logic [5:0] p, input logic d);
    return {d ^ (^(p & GEN_A)), d ^ (^(p & GEN_B))};
  endfunction

  // True when a is "smaller" than b under modulo-2^w arithmetic, i.e. the
  // w-bit difference a-b has its sign bit set. Operands are zero-extended
  // w-bit metrics; the low w bits of the wide difference are exact.
  function automatic logic mod_less(input wide_metric_t a, input wide_metric_t b,
                                    input int w);
    wide_metric_t diff;
    diff = a - b;
    return ((diff >> (w - 1)) & MAX_METRIC_W'(1)) != '0;
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state plus its register-exchange
// survivor. The state index is a parameter so both predecessor branch
// labels reduce to constants at elaboration.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int STATE    = 0,
  parameter int METRIC_W = 6,
  parameter int TB_DEPTH = 36
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                valid,
  input  logic                data_a,
  input  logic                data_b,
  input  logic [METRIC_W-1:0] pm_p0,
  input  logic [METRIC_W-1:0] pm_p1,
  input  logic [TB_DEPTH-2:0] surv_p0,
  input  logic [TB_DEPTH-2:0] surv_p1,
  output logic [METRIC_W-1:0] pm,
  output logic [TB_DEPTH-1:0] surv
);

  localparam logic [5:0] S_IDX = 6'(STATE);
  localparam logic [5:0] P0    = {1'b0, S_IDX[5:1]};
  localparam logic [5:0] P1    = {1'b1, S_IDX[5:1]};
  localparam logic       D     = S_IDX[0];
  localparam logic [1:0] EXP0  = exp_out(P0, D);
  localparam logic [1:0] EXP1  = exp_out(P1, D);

  // State 0 starts ahead so decoding assumes the encoder began at zero.
  localparam logic [METRIC_W-1:0] INIT_PM =
    (STATE == 0) ? METRIC_W'(0) : METRIC_W'(1 << (METRIC_W - 2));

  logic [1:0]          bm0;
  logic [1:0]          bm1;
  logic [METRIC_W-1:0] c0;
  logic [METRIC_W-1:0] c1;
  logic                take_p1;

  // Hamming branch metrics, candidate sums and the modulo compare (tie -> p0).
  always_comb begin
    bm0     = {1'b0, EXP0[1] ^ data_a} + {1'b0, EXP0[0] ^ data_b};
    bm1     = {1'b0, EXP1[1] ^ data_a} + {1'b0, EXP1[0] ^ data_b};
    c0      = pm_p0 + METRIC_W'(bm0);
    c1      = pm_p1 + METRIC_W'(bm1);
    take_p1 = mod_less(MAX_METRIC_W'(c1), MAX_METRIC_W'(c0), METRIC_W);
  end

  // Metric and survivor update; clear has priority and discards the pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm   <= INIT_PM;
      surv <= '0;
    end else if (clear) begin
      pm   <= INIT_PM;
      surv <= '0;
    end else if (valid) begin
      pm   <= take_p1 ? c1 : c0;
      surv <= {(take_p1 ? surv_p1 : surv_p0), D};
    end
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the 802.11a K=7 rate-1/2 code.
// 64 ACS cells with register-exchange survivors; the output stage picks
// the best metric one cycle later and emits the oldest survivor bit.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 36,
  parameter int METRIC_W = 6
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iClear,
  input  logic iValid,
  input  logic iDataA,
  input  logic iDataB,
  output logic oData,
  output logic oValid
);

  localparam int STATE_BITS = K - 1;
  localparam int HALF       = NUM_STATES / 2;
  localparam int CNT_W      = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(TB_DEPTH);

  logic [METRIC_W-1:0]   pm_q   [NUM_STATES];
  logic [TB_DEPTH-1:0]   surv_q [NUM_STATES];
  logic [CNT_W-1:0]      fill_cnt;
  logic                  filled;
  logic                  valid_d;
  logic [STATE_BITS-1:0] best;

  // Successor s has predecessors s>>1 (oldest bit 0) and (s>>1)+32 (oldest bit 1).
  for (genvar s = 0; s < NUM_STATES; s++) begin : gen_acs
    viterbi_acs #(
      .STATE    (s),
      .METRIC_W (METRIC_W),
      .TB_DEPTH (TB_DEPTH)
    ) u_acs (
      .clk     (iClk),
      .rst_n   (iRstN),
      .clear   (iClear),
      .valid   (iValid),
      .data_a  (iDataA),
      .data_b  (iDataB),
      .pm_p0   (pm_q[s / 2]),
      .pm_p1   (pm_q[s / 2 + HALF]),
      .surv_p0 (surv_q[s / 2][TB_DEPTH-2:0]),
      .surv_p1 (surv_q[s / 2 + HALF][TB_DEPTH-2:0]),
      .pm      (pm_q[s]),
      .surv    (surv_q[s])
    );
  end

  assign filled = (fill_cnt == FULL);

  // Best-state search over registered metrics; strict compare keeps the lowest index on ties.
  always_comb begin
    best = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (mod_less(MAX_METRIC_W'(pm_q[s]), MAX_METRIC_W'(pm_q[best]), METRIC_W)) begin
        best = STATE_BITS'(s);
      end
    end
  end

  // Accepted-pair counter, saturating once the survivors hold a full decision depth.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      fill_cnt <= '0;
    end else if (iClear) begin
      fill_cnt <= '0;
    end else if (iValid && !filled) begin
      fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  // Remember that an ACS update happened so the output stage fires one cycle later.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      valid_d <= 1'b0;
    end else if (iClear) begin
      valid_d <= 1'b0;
    end else begin
      valid_d <= iValid;
    end
  end

  // Output register: oldest bit of the best survivor, qualified by fill state.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oData  <= 1'b0;
      oValid <= 1'b0;
    end else if (iClear) begin
      oData  <= 1'b0;
      oValid <= 1'b0;
    end else begin
      oData  <= surv_q[best][TB_DEPTH-1];
      oValid <= valid_d & filled;
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: a hand-computed vector table
// (zero stream, clear-with-valid, impulse) followed by encoded random
// packets with errors, throttling, clears and an asynchronous reset.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 36;
  localparam int METRIC_W = 6;
  localparam int NV       = 168;

  logic iClk = 1'b0;
  logic iRstN;
  logic iClear;
  logic iValid;
  logic iDataA;
  logic iDataB;
  logic oData;
  logic oValid;

  viterbi_decoder #(
    .TB_DEPTH (TB_DEPTH),
    .METRIC_W (METRIC_W)
  ) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iClear (iClear),
    .iValid (iValid),
    .iDataA (iDataA),
    .iDataB (iDataB),
    .oData  (oData),
    .oValid (oValid)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    bit clr;
    bit v;
    bit a;
    bit b;
    bit exp_valid;
    bit exp_data;
  } vec_t;

  vec_t     vecs [NV];
  bit [1:0] imp_pairs [7];
  int       n_checks = 0;
  int       n_fail   = 0;
  bit       exp_q [$];
  bit [5:0] enc_state;
  int       pair_idx;
  bit       flip_b;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference TX encoder, shift register with newest bit in enc_state[0].
  task automatic encodeBit(input bit d, output bit a, output bit b);
    a = d ^ enc_state[1] ^ enc_state[2] ^ enc_state[4] ^ enc_state[5];
    b = d ^ enc_state[0] ^ enc_state[1] ^ enc_state[2] ^ enc_state[5];
    enc_state = {enc_state[4:0], d};
  endtask

  task automatic monitorStream();
    bit e;
    if (oValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected oValid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("stream data", oData, e);
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input bit a, input bit b, input bit clr);
    @(negedge iClk);
    monitorStream();
    iValid = v;
    iDataA = a;
    iDataB = b;
    iClear = clr;
  endtask

  task automatic startPacket();
    enc_state = '0;
    exp_q.delete();
    pair_idx = 0;
    flip_b = 1'b0;
  endtask

  task automatic sendBit(input bit d, input bit throttle, input bit errors);
    bit a;
    bit b;
    int idles;
    if (throttle) begin
      idles = 0;
      while ($urandom_range(99) >= 30 && idles < 20) begin
        applyStimulus(0, 0, 0, 0);
        idles++;
      end
    end
    encodeBit(d, a, b);
    if (errors && (pair_idx % 20 == 19)) begin
      if (flip_b) b = ~b;
      else        a = ~a;
      flip_b = ~flip_b;
    end
    pair_idx++;
    applyStimulus(1, a, b, 0);
    exp_q.push_back(d);
  endtask

  task automatic sendPacket(input int n, input bit throttle, input bit errors);
    for (int i = 0; i < n; i++) sendBit(1'($urandom_range(1)), throttle, errors);
    for (int i = 0; i < 6; i++) sendBit(1'b0, throttle, errors);
  endtask

  task automatic flushAndCheck(input string name);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput(name, exp_q.size(), TB_DEPTH - 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRstN  = 1'b0;
    iClear = 1'b0;
    iValid = 1'b0;
    iDataA = 1'b0;
    iDataB = 1'b0;
    startPacket();

    // Zero stream; the output of row 99 lands on the clear edge and is wiped.
    for (int i = 0; i < 100; i++) vecs[i] = '{0, 1, 0, 0, (i >= 35 && i <= 98), 0};
    // Clear together with valid: pair discarded, outputs forced low.
    vecs[100] = '{1, 1, 1, 1, 0, 0};
    // Impulse response of a single 1 from state 0, then zeros.
    imp_pairs = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    for (int j = 0; j < 67; j++) begin
      bit [1:0] pr;
      pr = (j < 7) ? imp_pairs[j] : 2'b00;
      vecs[101 + j] = '{0, 1, pr[1], pr[0], (j >= 35), (j == 35)};
    end

    repeat (2) @(negedge iClk);
    checkOutput("reset oValid", oValid, 0);
    checkOutput("reset oData", oData, 0);
    checkOutput("reset pm[0]", dut.pm_q[0], 0);
    checkOutput("reset pm[1]", dut.pm_q[1], 16);
    checkOutput("reset pm[63]", dut.pm_q[63], 16);
    iRstN = 1'b1;

    // Row i is driven at negedge i; its result is visible two negedges later.
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge iClk);
      if (i >= 2) begin
        checkOutput($sformatf("vec%0d oValid", i - 2), oValid, vecs[i-2].exp_valid);
        checkOutput($sformatf("vec%0d oData", i - 2), oData, vecs[i-2].exp_data);
      end
      if (i < NV) begin
        iClear = vecs[i].clr;
        iValid = vecs[i].v;
        iDataA = vecs[i].a;
        iDataB = vecs[i].b;
      end else begin
        iClear = 1'b0;
        iValid = 1'b0;
        iDataA = 1'b0;
        iDataB = 1'b0;
      end
    end

    // Clean golden packet, back-to-back.
    applyStimulus(0, 0, 0, 1);
    startPacket();
    sendPacket(250, 0, 0);
    flushAndCheck("golden pending bits");

    // Throttled packet with periodic single errors, cut short by clear+valid.
    applyStimulus(0, 0, 0, 1);
    startPacket();
    sendPacket(150, 1, 1);
    applyStimulus(1, 1, 0, 1);
    startPacket();

    // New packet after the clear, throttled with errors.
    sendPacket(200, 1, 1);
    flushAndCheck("post-clear pending bits");

    // Clean packet interrupted by an asynchronous reset between edges.
    applyStimulus(0, 0, 0, 1);
    startPacket();
    for (int i = 0; i < 200; i++) sendBit(1'($urandom_range(1)), 0, 0);
    @(posedge iClk);
    #2;
    iRstN  = 1'b0;
    iValid = 1'b0;
    iClear = 1'b0;
    #1;
    checkOutput("async reset oValid", oValid, 0);
    checkOutput("async reset oData", oData, 0);
    checkOutput("async reset pm[0]", dut.pm_q[0], 0);
    checkOutput("async reset pm[9]", dut.pm_q[9], 16);
    startPacket();
    #10;
    iRstN = 1'b1;

    // Refill after reset behaves like a fresh golden packet.
    sendPacket(150, 0, 0);
    flushAndCheck("refill pending bits");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
